// File: rtl/zero_detect_arbiter.sv
// rtl/zero_detect_arbiter.sv - round-robin shared 64-bit zero-detect unit with tagged response
// Optional macro ZD_PIPE_EN splits the reduction into two registered half-width stages.
module zero_detect_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 64,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IDW-1:0]           rsp_id,
    output logic                     rsp_zero,
    output logic                     busy
);

`ifdef ZD_PIPE_EN
    typedef enum logic [1:0] {IDLE, EVAL_LO, EVAL_HI, RESP} state_t;
`else
    typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;
`endif

    state_t             state;
    state_t             state_next;
    logic [IDW-1:0]     rr_ptr;
    logic [WIDTH-1:0]   op_reg;
    logic [IDW-1:0]     id_reg;
    logic [IDW-1:0]     grant;
    logic               grant_found;
    logic               accept;
`ifdef ZD_PIPE_EN
    logic               lo_or;
    logic               hi_or;
`endif

    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IDW'(s);
    endfunction

    // First valid requester at or above rr_ptr, wrapping around.
    always_comb begin
        grant       = '0;
        grant_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_found && req_valid[wrap_add(rr_ptr, k)]) begin
                grant       = wrap_add(rr_ptr, k);
                grant_found = 1'b1;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && !reset && grant_found) req_ready[grant] = 1'b1;
    end

    assign accept = |req_ready;
    assign busy   = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
`ifdef ZD_PIPE_EN
            IDLE:    if (accept) state_next = EVAL_LO;
            EVAL_LO: state_next = EVAL_HI;
            EVAL_HI: state_next = RESP;
`else
            IDLE:    if (accept) state_next = EVAL;
            EVAL:    state_next = RESP;
`endif
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr    <= '0;
            op_reg    <= '0;
            id_reg    <= '0;
            rsp_valid <= 1'b0;
            rsp_zero  <= 1'b0;
            rsp_id    <= '0;
`ifdef ZD_PIPE_EN
            lo_or     <= 1'b0;
            hi_or     <= 1'b0;
`endif
        end else begin
            if (accept) begin
                op_reg <= req_data[grant*WIDTH +: WIDTH];
                id_reg <= grant;
                rr_ptr <= wrap_add(grant, 1);
            end
`ifdef ZD_PIPE_EN
            if (state == EVAL_LO) begin
                lo_or <= |op_reg[WIDTH/2-1:0];
                hi_or <= |op_reg[WIDTH-1:WIDTH/2];
            end
            if (state == EVAL_HI) begin
                rsp_zero  <= ~(lo_or | hi_or);
                rsp_id    <= id_reg;
                rsp_valid <= 1'b1;
            end
`else
            if (state == EVAL) begin
                rsp_zero  <= ~|op_reg;
                rsp_id    <= id_reg;
                rsp_valid <= 1'b1;
            end
`endif
            // rsp_valid is high exactly while in RESP
            if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_zero_detect_arbiter.sv
// tb/tb_zero_detect_arbiter.sv - self-checking bench for zero_detect_arbiter
module tb_zero_detect_arbiter;
    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 64;
`ifdef ZD_PIPE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [1:0]               rsp_id;
    logic                     rsp_zero;
    logic                     busy;

    int          n_cmp  = 0;
    int          n_fail = 0;
    int          m_ptr  = 0;
    logic [63:0] m_data [4];

    always #5 clk = ~clk;

    zero_detect_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_zero(rsp_zero), .busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_data(input int i, input logic [63:0] v);
        m_data[i] = v;
        req_data[i*WIDTH +: WIDTH] = v;
    endtask

    function automatic int model_grant(input logic [3:0] v);
        for (int k = 0; k < NUM_REQ; k++)
            if (v[(m_ptr + k) % NUM_REQ]) return (m_ptr + k) % NUM_REQ;
        return -1;
    endfunction

    function automatic logic [63:0] rand_data();
        case ($urandom_range(0, 3))
            0:       return 64'd0;
            1:       return 64'd1 << $urandom_range(0, 63);
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Called at a falling edge with the DUT idle; returns at a falling edge, idle again.
    task automatic txn(input logic [3:0] vld, input int hold);
        int          g;
        logic [3:0]  exp_rdy;
        logic [63:0] exp_zero;
        g        = model_grant(vld);
        exp_rdy  = 4'b0001 << g;
        exp_zero = 64'(m_data[g] == 64'd0);
        req_valid = vld;
        rsp_ready = 1'b0;
        #1;
        check("grant_onehot", 64'(req_ready), 64'(exp_rdy));
        m_ptr = (g + 1) % NUM_REQ;
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        #1;
        check("eval_busy", 64'(busy), 64'd1);
        check("eval_no_rsp", 64'(rsp_valid), 64'd0);
        check("eval_no_ready", 64'(req_ready), 64'd0);
        repeat (LAT - 1) @(negedge clk);
        #1;
        check("rsp_valid", 64'(rsp_valid), 64'd1);
        check("rsp_id", 64'(rsp_id), 64'(g));
        check("rsp_zero", 64'(rsp_zero), exp_zero);
        for (int h = 0; h < hold; h++) begin
            req_valid = 4'hF;
            @(negedge clk);
            #1;
            check("hold_valid", 64'(rsp_valid), 64'd1);
            check("hold_id", 64'(rsp_id), 64'(g));
            check("hold_zero", 64'(rsp_zero), exp_zero);
            check("hold_no_ready", 64'(req_ready), 64'd0);
            check("hold_busy", 64'(busy), 64'd1);
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        check("done_valid", 64'(rsp_valid), 64'd0);
        check("done_busy", 64'(busy), 64'd0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_ptr = 0;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 4'hF;
        rsp_ready = 1'b0;
        req_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) set_data(i, 64'd0);

        // reset state, with every requester asking
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset_ready", 64'(req_ready), 64'd0);
        check("reset_valid", 64'(rsp_valid), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_id", 64'(rsp_id), 64'd0);
        check("reset_zero", 64'(rsp_zero), 64'd0);
        reset     = 1'b0;
        req_valid = '0;

        // idle for 10 cycles
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            check("idle_ready", 64'(req_ready), 64'd0);
            check("idle_valid", 64'(rsp_valid), 64'd0);
            check("idle_busy", 64'(busy), 64'd0);
        end
        @(negedge clk);

        // single zero operand from requester 2
        set_data(2, 64'd0);
        txn(4'b0100, 0);

        // requester 0 with non-zero boundary operands
        set_data(0, 64'd572613);
        txn(4'b0001, 0);
        set_data(0, 64'h8000_0000_0000_0000);
        txn(4'b0001, 0);
        set_data(0, 64'd1);
        txn(4'b0001, 0);

        // response back-pressure for 5 cycles
        set_data(1, 64'd0);
        txn(4'b0010, 5);

        // reset in the middle of evaluating requester 3
        req_valid = 4'b1000;
        #1;
        check("pre_reset_grant", 64'(req_ready), 64'b1000);
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        reset     = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_ptr = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("dropped_valid", 64'(rsp_valid), 64'd0);
            check("dropped_busy", 64'(busy), 64'd0);
            @(negedge clk);
        end
        txn(4'b1001, 0);

        // round robin with all requesters held valid: 0,1,2,3,0
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_data(i, (i % 2 == 0) ? 64'd0 : 64'd5);
        for (int n = 0; n < 5; n++) txn(4'b1111, 0);

        // randomized traffic against the model
        for (int n = 0; n < 25; n++) begin
            for (int i = 0; i < NUM_REQ; i++) set_data(i, rand_data());
            txn(4'($urandom_range(1, 15)), $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/zero_detect_arbiter.md
# zero_detect_arbiter

Shares one 64-bit zero-detect reduction unit (NOR of all operand bits) between several requesters, e.g. ALU flag logic, branch-compare logic and test/debug ports. A round-robin arbiter accepts one operand at a time over a valid/ready handshake. The block sequences the evaluation through a small state machine and returns a tagged, registered result over a second valid/ready handshake. It sits beside the ALU in the datapath and is the only owner of the shared zero-detect unit.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 64, operand width in bits
- IDW, $clog2(NUM_REQ), requester-ID width (derived; not overridden)

- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  NUM_REQ  per-requester operand valid
- req_data  input  NUM_REQ*WIDTH  operands; requester i at bits [i*WIDTH +: WIDTH]
- req_ready  output  NUM_REQ  one-hot grant/accept strobe, combinational
- rsp_valid  output  1  result valid
- rsp_ready  input  1  consumer accepts result
- rsp_id  output  IDW  index of requester the result belongs to
- rsp_zero  output  1  1 iff every bit of the accepted operand was 0
- busy  output  1  1 whenever state != IDLE

## Operation
- States: IDLE, EVAL, RESP. With ZD_PIPE_EN the states are IDLE, EVAL_LO, EVAL_HI, RESP.
- IDLE:
  - Grant goes to the first i with req_valid[i] = 1, scanning from rr_ptr upward with wrap.
  - req_ready[grant] = 1 (only while in IDLE and reset = 0).
  - On that edge: op_reg <= req_data[grant], id_reg <= grant, rr_ptr <= (grant+1) mod NUM_REQ, state -> EVAL.
  - With no valid request, remain in IDLE.
- EVAL: rsp_zero <= ~|op_reg, rsp_id <= id_reg, rsp_valid <= 1, state -> RESP.
- RESP: hold rsp_valid, rsp_id and rsp_zero stable. On rsp_valid & rsp_ready: rsp_valid <= 0, state -> IDLE.
- No new request is accepted in EVAL or RESP; req_ready is all-zero there.
- req_ready may depend on req_valid. A requester must not make req_valid depend on req_ready, and must hold req_valid and its data until accepted.
- Requests with req_valid deasserted before grant are simply never accepted; no error.
- Width rule: the reduction covers exactly WIDTH bits; no sign or extension handling.
- Reset (any state, including mid-EVAL or RESP):
  - state -> IDLE, rr_ptr <= 0, rsp_valid <= 0, rsp_zero <= 0, rsp_id <= 0, op_reg <= 0, id_reg <= 0.
  - The in-flight transaction is dropped with no response.
  - req_ready = 0 while reset = 1.

## Timing
- Cycle 0 is the cycle in which req_valid[i] & req_ready[i] = 1.
- Without ZD_PIPE_EN:
  - Cycle 1: state EVAL.
  - Cycle 2: rsp_valid = 1 (2-cycle latency).
  - If rsp_ready = 1 in cycle 2, the next grant is possible in cycle 3.
  - Peak throughput: 1 result per 3 cycles.
- With ZD_PIPE_EN: rsp_valid first high in cycle 3; peak throughput 1 per 4 cycles.
- Outputs are registered except req_ready (combinational from req_valid, rr_ptr and state) and busy (decoded from state).
- Round-robin fairness: a continuously valid requester is granted within NUM_REQ grants.

## Configuration
- ZD_PIPE_EN defined:
  - EVAL is split into two stages.
  - EVAL_LO registers two half-width OR reductions: lo_or <= |op_reg[WIDTH/2-1:0], hi_or <= |op_reg[WIDTH-1:WIDTH/2].
  - EVAL_HI computes rsp_zero <= ~(lo_or | hi_or).
  - Adds one cycle of latency and shortens the critical path for higher clock rates.
  - WIDTH must be even.
  - Reset clears lo_or and hi_or to 0.
- ZD_PIPE_EN undefined: single EVAL state with a full-width reduction, as described above.

## Test plan
- Reset, then req_valid = 4'b0100 with req_data[2] = 0 → req_ready = 4'b0100 in cycle 0; rsp_valid = 1, rsp_id = 2, rsp_zero = 1 in cycle 2 (cycle 3 with ZD_PIPE_EN).
- Requester 0 data 64'd572613 → rsp_zero = 0. Then data 64'h8000_0000_0000_0000 → rsp_zero = 0. Then data 64'd1 → rsp_zero = 0.
- req_valid = 4'b1111 held with rsp_ready = 1 → grant order 0,1,2,3,0. Each rsp_id matches its grant; exactly one req_ready bit high per grant.
- rsp_ready held 0 for 5 cycles during RESP → rsp_valid, rsp_id and rsp_zero stable; req_ready = 0 and busy = 1 throughout; raising rsp_ready returns the block to IDLE on the next edge.
- reset pulsed during EVAL after granting requester 3 → no rsp_valid afterwards. With req_valid = 4'b1001, the next grant goes to requester 0 (rr_ptr reset to 0).
- No requests for 10 cycles after reset → req_ready = 0, rsp_valid = 0, busy = 0.
